// File: rtl/tpu_pkg.sv
// tpu_pkg: widths and feeder state encoding shared by the memory, feeder and MAC array.
package tpu_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int DIM = 4;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} feeder_state_e;
endpackage

// File: rtl/skew_lane_ctrl.sv
// skew_lane_ctrl: maps the shared feed step onto one lane's diagonally skewed read request.
module skew_lane_ctrl #(
  parameter int LANE = 0,
  parameter int SW = 3
) (
  input  logic [SW-1:0] t,
  input  logic          stalled,
  output logic          read_enable,
  output logic [1:0]    read_elem,
  output logic          active
);
  import tpu_pkg::*;
  logic [SW-1:0] d;
  // t < LANE wraps d far above DIM-1, so one compare covers both window edges
  assign d = t - SW'(LANE);
  assign active = !stalled && d <= SW'(DIM - 1);
  assign read_enable = active;
  assign read_elem = active ? d[1:0] : 2'b0;
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: streams one 4x4 tile from the operand memory into the MAC array
// with per-lane wavefront skew, then waits a drain interval before pulsing done.
module systolic_feeder #(
  parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               stall,
  output logic                               busy,
  output logic                               done,
  output logic [tpu_pkg::DIM-1:0]            mem_read_enable,
  output logic [2*tpu_pkg::DIM-1:0]          mem_read_elem,
  input  logic [tpu_pkg::DIM*DATA_WIDTH-1:0] mem_data,
  output logic [tpu_pkg::DIM*DATA_WIDTH-1:0] feed_data,
  output logic [tpu_pkg::DIM-1:0]            feed_valid
);
  import tpu_pkg::*;
  localparam int STEP_MAX = 2 * DIM - 2;
  localparam int SW = $clog2(STEP_MAX + 1);
  feeder_state_e state, state_d;
  logic [SW-1:0] step;
  logic [DIM-1:0] active;
  logic hold, step_last, drain_last;
  assign hold = stall || state != FEED;
  assign step_last = step == SW'(STEP_MAX);
  assign busy = state != IDLE;
  assign done = state == DONE;
  for (genvar k = 0; k < DIM; k++) begin : g_lane
    skew_lane_ctrl #(.LANE(k), .SW(SW)) u_lane (
      .t(step),
      .stalled(hold),
      .read_enable(mem_read_enable[k]),
      .read_elem(mem_read_elem[2*k +: 2]),
      .active(active[k])
    );
  end
  if (DRAIN_CYCLES > 0) begin : g_drain
    localparam int DCW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
    logic [DCW-1:0] cnt;
    assign drain_last = cnt == DCW'(DRAIN_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (state != DRAIN) cnt <= '0;
      else if (!stall) cnt <= cnt + 1'b1;
  end else begin : g_no_drain
    assign drain_last = 1'b1;
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = start ? FEED : IDLE;
      FEED: state_d = (!stall && step_last) ? (DRAIN_CYCLES == 0 ? DONE : DRAIN) : FEED;
      DRAIN: state_d = (!stall && drain_last) ? DONE : DRAIN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step <= '0;
      feed_valid <= '0;
      feed_data <= '0;
    end else begin
      state <= state_d;
      step <= state != FEED ? '0 : (!stall && !step_last) ? step + 1'b1 : step;
      feed_valid <= active;
      for (int k = 0; k < DIM; k++)
        if (active[k]) feed_data[k*DATA_WIDTH +: DATA_WIDTH] <= mem_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end
endmodule
